uart_byte_receiver: RTL and testbench
=====================================

Name: uart_byte_receiver

Overview:
- Serial front end of the matrix-data receive path. It samples the asynchronous `rx_data` line and reconstructs 8N1 UART frames.
- Each good frame yields one byte plus a one-cycle `byte_valid` strobe. The downstream receive counter and matrix loader count and store these strobes.
- The block detects false starts and framing errors so that downstream logic never sees corrupt bytes.

Parameters:
- CLKS_PER_BIT, 1302, clock cycles per UART bit. Must be ≥ 4. HALF_BIT = CLKS_PER_BIT/2, integer division.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  1  asynchronous serial line; idles high.
- rx_byte  output  DATA_BITS  last correctly received byte.
- byte_valid  output  1  one-cycle pulse; rx_byte is new on this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. With rst high at a clk edge:
  - state=IDLE; rx_byte=0; byte_valid=0; frame_err=0; busy=0.
  - Synchronizer flops preset to 1; bit and cycle counters cleared.
- Reset mid-frame aborts the frame. No byte_valid and no frame_err are produced for it.
- Input path: two-flop synchronizer feeds rx_s. All decisions use rx_s only. Line-to-rx_s latency is 2 cycles.
- Counters:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits wide and reloads to 0 at each sample point.
  - Bit index is $clog2(DATA_BITS+1) bits wide.
- Timing reference: t0 is the first cycle where the FSM is in IDLE and rx_s=0.
- IDLE: on rx_s=0, clear the counter and go to START.
- START: at t0+HALF_BIT, sample rx_s.
  - rx_s=1: false start; return to IDLE. No output pulse.
  - rx_s=0: go to DATA with bit index 0.
- DATA: bit k is sampled at t0+HALF_BIT+(k+1)*CLKS_PER_BIT and shifted in LSB first. After bit DATA_BITS-1, go to STOP.
- STOP: sample at t0+HALF_BIT+(DATA_BITS+1)*CLKS_PER_BIT.
  - rx_s=1: on the next cycle, rx_byte gets the shift register, byte_valid=1 for exactly 1 cycle, and the FSM returns to IDLE.
  - rx_s=0: on the next cycle, frame_err=1 for 1 cycle and rx_byte is unchanged. Go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This covers break conditions: a line held low never generates repeated frames.
- Back-to-back frames: after a valid stop, IDLE is re-entered mid stop bit. The next start edge is accepted with no dead time beyond the remaining half bit.
- The shift register is internal. rx_byte changes only with byte_valid and holds indefinitely otherwise.
- byte_valid and frame_err are never high in the same cycle.
- busy=1 in START, DATA, STOP and WAIT_IDLE.

Test Plan (benches use CLKS_PER_BIT=16, DATA_BITS=8):
- Reset with rx_data=1, then 100 idle cycles. Required: all outputs 0; busy=0 throughout.
- Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), each bit held 16 cycles.
  - Required: exactly one byte_valid pulse with rx_byte=8'hA5.
  - The pulse comes 2+8+9*16+1 = 155 cycles after the start edge on rx_data, ±1.
- Send 0x00, 0xFF and 0x3C back-to-back with 1-bit stop. Required: three byte_valid pulses carrying 00, FF and 3C in order; frame_err never high.
- Glitch: drive rx_data low for 5 cycles, then high. Required: busy pulses and returns to 0; no byte_valid; no frame_err; rx_byte unchanged.
- Send 0x5A with stop bit forced 0, then hold rx_data low for 200 cycles, then high, then send 0x11.
  - Required: one frame_err pulse; rx_byte stays at its previous value during the break.
  - Required: no additional pulses during the break; 0x11 is then received correctly.
- Assert rst for 1 cycle during data bit 3 of 0xC3, then send 0x7E. Required: no output for the aborted frame; 0x7E is received with byte_valid.

Source files
------------

// File: rtl/uart_byte_receiver_if.sv
// uart_byte_receiver_if
// Groups the serial line and the received-byte outputs of the UART byte
// receiver into one bundle.
//   rx_data    : serial line, idles high (driven by the line side)
//   rx_byte    : last correctly received byte
//   byte_valid : one-cycle strobe, rx_byte is new on this cycle
//   frame_err  : one-cycle strobe, stop bit was sampled low
//   busy       : receiver is somewhere other than IDLE
// master = line driver / byte consumer, slave = the receiver itself.
interface uart_byte_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_data;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_data,
        input  rx_byte,
        input  byte_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_data,
        output rx_byte,
        output byte_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver
// 8N1 UART receive front end. The asynchronous line is brought in through a
// two-flop synchronizer; a small FSM centres its sampling on each bit using a
// half-bit offset from the detected start edge. A good frame produces one
// byte with a single-cycle byte_valid strobe; a low stop bit produces a
// single-cycle frame_err strobe and the receiver then waits for the line to
// return high before it looks for another start bit.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : uart_byte_receiver_if slave (rx_data in; rx_byte, byte_valid,
//         frame_err, busy out)
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int DATA_BITS    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_byte_receiver_if.slave        bus
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W    = $clog2(DATA_BITS + 1);

    // Counter values on the cycle a sample is taken (counter starts at 0 on
    // the cycle after the previous decision).
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [1:0]           sync_reg;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] byte_reg;
    logic                 valid_reg;
    logic                 ferr_reg;
    logic                 busy_next;
    logic                 half_hit;
    logic                 bit_hit;

    // Two-flop synchronizer; preset high so reset never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], bus.rx_data};
        end
    end

    assign rx_s     = sync_reg[1];
    assign half_hit = (cnt_reg == HALF_LAST);
    assign bit_hit  = (cnt_reg == BIT_LAST);

    // LSB-first: each new bit enters at the MSB and older bits move down,
    // so after DATA_BITS shifts the first bit sits in bit 0.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_msb
                assign shift_next[gi] = rx_s;
            end else begin : g_low
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_hit) begin
                    // Line back high at mid start bit: a glitch, not a frame.
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_hit && (idx_reg == IDX_LAST)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Returning to IDLE mid stop bit lets a back-to-back start
                // edge be caught with no extra dead time.
                if (bit_hit) begin
                    state_next = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A held-low (break) line must not be decoded as frames.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_next = (state_reg != IDLE);
    end

    // Counters, shift register and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            byte_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    idx_reg <= '0;
                end
                START: begin
                    idx_reg <= '0;
                    if (half_hit) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        cnt_reg   <= '0;
                        shift_reg <= shift_next;
                        idx_reg   <= idx_reg + IDX_W'(1);
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_hit) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            byte_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                        end else begin
                            ferr_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    cnt_reg <= '0;
                end
                default: begin
                    cnt_reg <= '0;
                    idx_reg <= '0;
                end
            endcase
        end
    end

    assign bus.rx_byte    = byte_reg;
    assign bus.byte_valid = valid_reg;
    assign bus.frame_err  = ferr_reg;
    assign bus.busy       = busy_next;
endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver
// Directed bench for uart_byte_receiver at CLKS_PER_BIT=16, DATA_BITS=8.
// Frames are driven bit by bit on the line; a negedge monitor counts the
// output strobes and logs each received byte with its arrival cycle.
module tb_uart_byte_receiver;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_byte_receiver_if #(.DATA_BITS(8)) bus ();

    uart_byte_receiver #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc = 0;

    // Monitor state (written only by the monitor process)
    int        v_cnt    = 0;
    int        f_cnt    = 0;
    int        b_cnt    = 0;
    int        both_cnt = 0;
    logic [7:0] v_byte [0:63];
    int        v_cyc  [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.byte_valid === 1'b1) begin
                if (v_cnt < 64) begin
                    v_byte[v_cnt] = bus.rx_byte;
                    v_cyc[v_cnt]  = cyc;
                end
                v_cnt = v_cnt + 1;
            end
            if (bus.frame_err === 1'b1) f_cnt = f_cnt + 1;
            if (bus.busy === 1'b1) b_cnt = b_cnt + 1;
            if (bus.byte_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt = both_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.rx_data = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        $display("tx byte 0x%02h stop=%0b at cycle %0d", b, stop, cyc);
        bus.rx_data = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    function automatic int byte_at(input int idx);
        if (idx < 0 || idx >= 64 || idx >= v_cnt) return -1;
        return int'(v_byte[idx]);
    endfunction

    initial begin
        int v0, f0, b0, lat;
        logic [7:0] c3;

        rst = 1'b1;
        bus.rx_data = 1'b1;
        tick(3);
        rst = 1'b0;

        // Reset and idle
        tick(100);
        check("idle_rx_byte", int'(bus.rx_byte), 0);
        check("idle_byte_valid", int'(bus.byte_valid), 0);
        check("idle_frame_err", int'(bus.frame_err), 0);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_busy_cycles", b_cnt, 0);
        check("idle_valid_count", v_cnt, 0);
        $display("idle phase done at cycle %0d", cyc);

        // Single byte 0xA5 with latency check
        v0 = v_cnt;
        send_byte(8'hA5, 1'b1);
        tick(4);
        check("a5_count", v_cnt - v0, 1);
        check("a5_byte", byte_at(v0), 'hA5);
        lat = (v_cnt > v0 && v0 < 64) ? v_cyc[v0] - start_cyc : -1;
        check("a5_latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
        check("a5_rx_byte_hold", int'(bus.rx_byte), 'hA5);

        // Back-to-back frames
        v0 = v_cnt;
        f0 = f_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        tick(4);
        check("b2b_count", v_cnt - v0, 3);
        check("b2b_byte0", byte_at(v0), 'h00);
        check("b2b_byte1", byte_at(v0 + 1), 'hFF);
        check("b2b_byte2", byte_at(v0 + 2), 'h3C);
        check("b2b_no_ferr", f_cnt - f0, 0);

        // Glitch shorter than half a bit
        v0 = v_cnt;
        f0 = f_cnt;
        b0 = b_cnt;
        $display("glitch 5 cycles at cycle %0d", cyc);
        bus.rx_data = 1'b0;
        tick(5);
        bus.rx_data = 1'b1;
        tick(30);
        check("glitch_busy_seen", (b_cnt > b0) ? 1 : 0, 1);
        check("glitch_busy_end", int'(bus.busy), 0);
        check("glitch_no_valid", v_cnt - v0, 0);
        check("glitch_no_ferr", f_cnt - f0, 0);
        check("glitch_rx_byte", int'(bus.rx_byte), 'h3C);

        // Framing error followed by a break, then recovery
        v0 = v_cnt;
        f0 = f_cnt;
        send_byte(8'h5A, 1'b0);
        tick(100);
        check("break_rx_byte_mid", int'(bus.rx_byte), 'h3C);
        check("break_busy_mid", int'(bus.busy), 1);
        tick(100);
        check("break_ferr_count", f_cnt - f0, 1);
        check("break_no_valid", v_cnt - v0, 0);
        check("break_rx_byte_end", int'(bus.rx_byte), 'h3C);
        bus.rx_data = 1'b1;
        tick(20);
        check("break_release_idle", int'(bus.busy), 0);
        send_byte(8'h11, 1'b1);
        tick(4);
        check("recover_count", v_cnt - v0, 1);
        check("recover_byte", byte_at(v0), 'h11);
        check("recover_no_extra_ferr", f_cnt - f0, 1);

        // Reset in the middle of data bit 3 of 0xC3
        v0 = v_cnt;
        f0 = f_cnt;
        c3 = 8'hC3;
        $display("tx byte 0xc3 aborted by reset at cycle %0d", cyc);
        bus.rx_data = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) send_bit(c3[i]);
        bus.rx_data = c3[3];
        tick(CPB / 2);
        rst = 1'b1;
        bus.rx_data = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(40);
        check("abort_no_valid", v_cnt - v0, 0);
        check("abort_no_ferr", f_cnt - f0, 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_rx_byte_reset", int'(bus.rx_byte), 0);
        send_byte(8'h7E, 1'b1);
        tick(4);
        check("after_abort_count", v_cnt - v0, 1);
        check("after_abort_byte", byte_at(v0), 'h7E);
        check("after_abort_rx_byte", int'(bus.rx_byte), 'h7E);

        check("never_both_strobes", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
